// File: rtl/chunked_adder_pkg.sv
// Shared types for the chunk-serial adder.
// Holds the FSM state enum and the chunk-index width helper.
package chunked_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/chunked_adder_rca.sv
// chunk_rca: CHUNK-bit combinational ripple-carry adder.
// Ports: a, b, ci in; s, co (carry out), cm (carry into MSB) out.
module chunk_rca #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             cm
);

  logic [CHUNK:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < CHUNK; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign co = c[CHUNK];
  assign cm = c[CHUNK-1];

endmodule

// File: rtl/chunked_adder.sv
// chunked_adder: WIDTH-bit adder working CHUNK bits per cycle,
// valid/ready in and out; `CHUNKED_ADDER_SUB_EN adds port sub (a-b).
module chunked_adder
  import chunked_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef CHUNKED_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
    $error("chunked_adder: CHUNK must be >= 1 and divide WIDTH");
  end

  localparam int N  = WIDTH / CHUNK;
  localparam int IW = idx_w(N);

  state_t state, nxt;

  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry;
  logic             cout_q;
  logic             ovf_q;
  logic             sub_i;
  logic             last;

  logic [CHUNK-1:0] ca;
  logic [CHUNK-1:0] cb;
  logic [CHUNK-1:0] cs;
  logic             cco;
  logic             ccm;

`ifdef CHUNKED_ADDER_SUB_EN
  assign sub_i = sub;
`else
  assign sub_i = 1'b0;
`endif

  assign last = (idx == IW'(N - 1));

  always_comb begin
    ca = '0;
    cb = '0;
    for (int k = 0; k < N; k++) begin
      if (idx == IW'(k)) begin
        ca = a_q[k*CHUNK +: CHUNK];
        cb = b_q[k*CHUNK +: CHUNK];
      end
    end
  end

  chunk_rca #(.CHUNK(CHUNK)) u_rca (
    .a  (ca),
    .b  (cb),
    .ci (carry),
    .s  (cs),
    .co (cco),
    .cm (ccm)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (in_valid)  nxt = RUN;
      RUN:     if (last)      nxt = DONE;
      DONE:    if (out_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (1'b1)
      (state == IDLE): in_ready  = 1'b1;
      (state == RUN):  busy      = 1'b1;
      (state == DONE): out_valid = 1'b1;
      default: ;
    endcase
  end

  // Subtract is folded in at latch time: b inverted, carry forced to 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      sum_q  <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= sub_i ? ~b : b;
            carry <= sub_i | cin;
            idx   <= '0;
          end
        end
        RUN: begin
          for (int k = 0; k < N; k++) begin
            if (idx == IW'(k)) sum_q[k*CHUNK +: CHUNK] <= cs;
          end
          carry <= cco;
          idx   <= last ? '0 : idx + IW'(1);
          if (last) begin
            cout_q <= cco;
            ovf_q  <= ccm ^ cco;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_chunked_adder.sv
// Scoreboard bench for chunked_adder: 32/4 and 32/32 instances,
// directed vectors, latency, backpressure and mid-run reset.
module tb_chunked_adder;

  logic        clk;
  logic        rst_n;

  logic        in_valid, in_ready;
  logic [31:0] a, b;
  logic        cin;
  logic        out_valid, out_ready;
  logic [31:0] sum;
  logic        cout, ovf, busy;

  logic        in_valid2, in_ready2;
  logic [31:0] a2, b2;
  logic        cin2;
  logic        out_valid2, out_ready2;
  logic [31:0] sum2;
  logic        cout2, ovf2, busy2;

`ifdef CHUNKED_ADDER_SUB_EN
  logic        sub, sub2;
`endif

  chunked_adder #(.WIDTH(32), .CHUNK(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef CHUNKED_ADDER_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  chunked_adder #(.WIDTH(32), .CHUNK(32)) dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid2),
    .in_ready  (in_ready2),
    .a         (a2),
    .b         (b2),
    .cin       (cin2),
`ifdef CHUNKED_ADDER_SUB_EN
    .sub       (sub2),
`endif
    .out_valid (out_valid2),
    .out_ready (out_ready2),
    .sum       (sum2),
    .cout      (cout2),
    .ovf       (ovf2),
    .busy      (busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] s;
    logic        co;
    logic        ov;
    longint      t;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];

  int compared   = 0;
  int mismatched = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic bad(input string nm);
    compared++;
    mismatched++;
    $display("FAIL %s: got event expected none", nm);
  endtask

  // Monitor, 4-bit chunk instance
  bit          seen1 = 0;
  bit          rdy1  = 0;
  logic [31:0] hs1;
  logic        hc1, ho1;

  always @(negedge clk) begin
    if (rdy1) begin
      chk("in_ready_after_hs", {63'd0, in_ready}, 64'd1);
      rdy1 = 0;
    end
    if (out_valid) begin
      if (!seen1) begin
        if (q1.size() == 0) bad("unexpected_out1");
        else begin
          chk("sum1", {32'd0, sum}, {32'd0, q1[0].s});
          chk("cout1", {63'd0, cout}, {63'd0, q1[0].co});
          chk("ovf1", {63'd0, ovf}, {63'd0, q1[0].ov});
          chk("lat1", 64'(($time - 5 - q1[0].t) / 10), 64'd8);
        end
        seen1 = 1;
        hs1 = sum; hc1 = cout; ho1 = ovf;
      end else begin
        chk("hold_sum", {32'd0, sum}, {32'd0, hs1});
        chk("hold_cout_ovf", {62'd0, cout, ovf}, {62'd0, hc1, ho1});
        chk("hold_in_ready", {63'd0, in_ready}, 64'd0);
      end
      if (out_ready) begin
        if (q1.size() > 0) void'(q1.pop_front());
        seen1 = 0;
        rdy1  = 1;
      end
    end
  end

  // Monitor, full-width chunk instance
  always @(negedge clk) begin
    if (out_valid2) begin
      if (q2.size() == 0) bad("unexpected_out2");
      else begin
        chk("sum2", {32'd0, sum2}, {32'd0, q2[0].s});
        chk("cout2_ovf2", {62'd0, cout2, ovf2},
            {62'd0, q2[0].co, q2[0].ov});
        chk("lat2", 64'(($time - 5 - q2[0].t) / 10), 64'd1);
        void'(q2.pop_front());
      end
    end
  end

  task automatic send1(input logic [31:0] ta, input logic [31:0] tb,
                       input logic tc, input logic ts,
                       input logic [31:0] es, input logic eco,
                       input logic eov);
    exp_t e;
    int   i;
    @(negedge clk);
    for (i = 0; i < 50 && !in_ready; i++) @(negedge clk);
    if (!in_ready) begin
      bad("in_ready_timeout1");
      return;
    end
    a = ta; b = tb; cin = tc; in_valid = 1'b1;
`ifdef CHUNKED_ADDER_SUB_EN
    sub = ts;
`endif
    e.s = es; e.co = eco; e.ov = eov; e.t = longint'($time) + 5;
    q1.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    a = 32'hDEADBEEF; b = 32'hDEADBEEF; cin = ~tc;
`ifdef CHUNKED_ADDER_SUB_EN
    sub = ~ts;
`endif
  endtask

  task automatic send2(input logic [31:0] ta, input logic [31:0] tb,
                       input logic tc, input logic [31:0] es,
                       input logic eco, input logic eov);
    exp_t e;
    int   i;
    @(negedge clk);
    for (i = 0; i < 50 && !in_ready2; i++) @(negedge clk);
    if (!in_ready2) begin
      bad("in_ready_timeout2");
      return;
    end
    a2 = ta; b2 = tb; cin2 = tc; in_valid2 = 1'b1;
    e.s = es; e.co = eco; e.ov = eov; e.t = longint'($time) + 5;
    q2.push_back(e);
    @(negedge clk);
    in_valid2 = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && (q1.size() > 0 || q2.size() > 0); i++)
      @(posedge clk);
    if (q1.size() > 0 || q2.size() > 0) bad("drain_timeout");
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
    in_valid2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0; out_ready2 = 1'b1;
`ifdef CHUNKED_ADDER_SUB_EN
    sub = 1'b0; sub2 = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_ready_valid_busy", {61'd0, in_ready, out_valid, busy}, 64'd4);
    chk("rst_sum_cout_ovf", {30'd0, sum, cout, ovf}, 64'd0);
    chk("rst_dut2", {61'd0, in_ready2, out_valid2, busy2}, 64'd4);
    rst_n = 1'b1;

    send1(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0);
    drain();
    send1(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1);
    drain();
    send1(32'h12345678, 32'h11111111, 1'b1, 1'b0, 32'h2345678A, 1'b0, 1'b0);
    drain();
    send1(32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1);
    drain();
    send1(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0);
    drain();

    @(posedge clk); #1 out_ready = 1'b0;
    send1(32'hA5A5A5A5, 32'h5A5A5A5A, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0);
    for (int i = 0; i < 50 && !out_valid; i++) @(posedge clk);
    repeat (5) @(posedge clk);
    #1 out_ready = 1'b1;
    drain();

    send1(32'h11111111, 32'h22222222, 1'b0, 1'b0, 32'h33333333, 1'b0, 1'b0);
    chk("busy_in_run", {62'd0, busy, in_ready}, 64'd2);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_flags", {61'd0, in_ready, out_valid, busy}, 64'd4);
    chk("mid_rst_sum", {30'd0, sum, cout, ovf}, 64'd0);
    q1.delete();
    @(negedge clk);
    rst_n = 1'b1;
    send1(32'h00000003, 32'h00000004, 1'b0, 1'b0, 32'h00000007, 1'b0, 1'b0);
    drain();

`ifdef CHUNKED_ADDER_SUB_EN
    send1(32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
    drain();
    send1(32'h00000007, 32'h00000005, 1'b1, 1'b1, 32'h00000002, 1'b1, 1'b0);
    drain();
`endif

    send2(32'h00000001, 32'h00000002, 1'b1, 32'h00000004, 1'b0, 1'b0);
    drain();
    send2(32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0);
    drain();
    send2(32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b1);
    drain();

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
